// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and sizing helper for the bit-serial subtractor
package serial_sub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit subtract-with-borrow cell
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial unsigned subtractor with start/done handshake
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh, diff_sh, diff_nx;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             d, bo;
  logic             last;

  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (brw),
    .d    (d),
    .bout (bo)
  );

  // New bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_one
      assign diff_nx = d;
    end else begin : g_many
      assign diff_nx = {d, diff_sh[WIDTH-1:1]};
    end
  endgenerate

  assign last = (cnt == LAST);
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last)  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      brw     <= 1'b0;
      cnt     <= '0;
      diff    <= '0;
      bout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            brw  <= bin;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          brw     <= bo;
          diff_sh <= diff_nx;
          cnt     <= cnt + CW'(1);
          // Result registers only change on the final bit, so the old result holds until then.
          if (last) begin
            diff <= diff_nx;
            bout <= bo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized and directed self-checking bench for serial_subtractor
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;
  logic       start2 = 1'b0, bin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, bout2;
  logic [1:0] diff2;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .bin(bin2),
    .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Timeline model: an accepted start yields the arithmetic result WIDTH edges later.
  int         t8 = 0, t2 = 0;
  logic       ed8 = 0, ed2 = 0;
  logic [8:0] res8 = '0, pend8 = '0;
  logic [2:0] res2 = '0, pend2 = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      t8 <= 0; ed8 <= 1'b0; res8 <= '0;
    end else if (t8 > 0) begin
      t8 <= t8 - 1;
      if (t8 == 1) begin ed8 <= 1'b1; res8 <= pend8; end
    end else if (ed8) begin
      ed8 <= 1'b0;
    end else if (start8) begin
      t8    <= 8;
      pend8 <= {1'b0, a8} - 9'(b8) - 9'(bin8);
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      t2 <= 0; ed2 <= 1'b0; res2 <= '0;
    end else if (t2 > 0) begin
      t2 <= t2 - 1;
      if (t2 == 1) begin ed2 <= 1'b1; res2 <= pend2; end
    end else if (ed2) begin
      ed2 <= 1'b0;
    end else if (start2) begin
      t2    <= 2;
      pend2 <= {1'b0, a2} - 3'(b2) - 3'(bin2);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy8", 32'(busy8), 32'(t8 > 0));
      check("done8", 32'(done8), 32'(ed8));
      check("result8", 32'({bout8, diff8}), 32'(res8));
      check("busy2", 32'(busy2), 32'(t2 > 0));
      check("done2", 32'(done2), 32'(ed2));
      check("result2", 32'({bout2, diff2}), 32'(res2));
    end
  end

  task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic bi);
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_done8(input string name);
    int k;
    for (k = 0; k < 40; k++) begin
      if (done8) break;
      @(negedge clk);
    end
    if (!done8) begin
      errors++;
      checks++;
      $display("FAIL %s: done timeout got 0 expected 1", name);
    end
  endtask

  initial begin
    int busy_cnt, done_at, pulses;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    check("reset_busy", 32'(busy8), 32'd0);
    check("reset_done", 32'(done8), 32'd0);
    check("reset_result", 32'({bout8, diff8}), 32'd0);

    // 1: latency and basic result
    start_op8(8'h05, 8'h03, 1'b0);
    busy_cnt = 0; done_at = 0;
    for (int k = 1; k <= 20; k++) begin
      if (busy8) busy_cnt++;
      if (done8 && done_at == 0) done_at = k;
      @(negedge clk);
    end
    check("t1_busy_cycles", 32'(busy_cnt), 32'd8);
    check("t1_done_cycle", 32'(done_at), 32'd9);
    check("t1_result", 32'({bout8, diff8}), 32'h002);

    // 2: underflow and hold
    start_op8(8'h00, 8'h01, 1'b0);
    wait_done8("t2");
    check("t2_result", 32'({bout8, diff8}), 32'h1FF);
    repeat (20) @(negedge clk);
    check("t2_hold", 32'({bout8, diff8}), 32'h1FF);

    // 3: borrow-in cases
    start_op8(8'h80, 8'h80, 1'b1);
    wait_done8("t3a");
    check("t3a_result", 32'({bout8, diff8}), 32'h1FF);
    @(negedge clk);
    start_op8(8'hFF, 8'h00, 1'b1);
    wait_done8("t3b");
    check("t3b_result", 32'({bout8, diff8}), 32'h0FE);
    @(negedge clk);

    // 4: start during RUN is ignored
    start_op8(8'h10, 8'h01, 1'b0);
    @(negedge clk);
    a8 = 8'h00; b8 = 8'hFF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      if (done8) pulses++;
      @(negedge clk);
    end
    check("t4_pulses", 32'(pulses), 32'd1);
    check("t4_result", 32'({bout8, diff8}), 32'h00F);

    // 5: reset mid-run
    start_op8(8'h33, 8'h11, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_busy", 32'(busy8), 32'd0);
    check("t5_done", 32'(done8), 32'd0);
    check("t5_result", 32'({bout8, diff8}), 32'd0);
    start_op8(8'h09, 8'h04, 1'b0);
    wait_done8("t5");
    check("t5_fresh", 32'({bout8, diff8}), 32'h005);
    @(negedge clk);

    // 6: WIDTH=2 exhaustive with start held high
    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      logic [2:0] exp2;
      int k;
      v = 5'(i);
      a2 = v[4:3]; b2 = v[2:1]; bin2 = v[0]; start2 = 1'b1;
      exp2 = {1'b0, v[4:3]} - 3'(v[2:1]) - 3'(v[0]);
      for (k = 0; k < 20; k++) begin
        @(negedge clk);
        if (done2) break;
      end
      check("t6_exhaustive", 32'({bout2, diff2}), 32'(exp2));
    end
    start2 = 1'b0;
    repeat (4) @(negedge clk);

    // Random operands against the model
    for (int n = 0; n < 40; n++) begin
      start_op8(8'($urandom), 8'($urandom), 1'($urandom));
      wait_done8("rand");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (12) @(negedge clk);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
